// File: rtl/wave_pkg.sv
// Shared types and reset constants for the waveform/thermometer generator.
package wave_pkg;

  typedef enum logic [1:0] {
    WM_TRI    = 2'd0,
    WM_SAW_UP = 2'd1,
    WM_SAW_DN = 2'd2,
    WM_HOLD   = 2'd3
  } wave_mode_e;

  localparam int RST_STEP = 1;
  localparam int RST_LO   = 0;

endpackage

// File: rtl/thermometer_encoder.sv
// Combinational binary-to-thermometer encoder: o_thermo[i] = (i < i_bin).
module thermometer_encoder #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 2**IN_WIDTH
) (
  input  logic [IN_WIDTH-1:0]  i_bin,
  output logic [OUT_WIDTH-1:0] o_thermo
);

  always_comb begin
    o_thermo = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      o_thermo[i] = ((IN_WIDTH+1)'(i) < {1'b0, i_bin});
    end
  end

endmodule

// File: rtl/wave_thermo_gen.sv
// Programmable triangle/sawtooth/hold counter with a registered thermometer copy.
// Bound arithmetic is done in WIDTH+1 bits so a step never wraps modulo 2**WIDTH.
module wave_thermo_gen
  import wave_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STEP_W    = 4,
  parameter int OUT_WIDTH = 2**WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cfg_load,
  input  logic [1:0]           cfg_mode,
  input  logic [STEP_W-1:0]    cfg_step,
  input  logic [WIDTH-1:0]     cfg_lo,
  input  logic [WIDTH-1:0]     cfg_hi,
  output logic [WIDTH-1:0]     count,
  output logic                 dir_up,
  output logic                 turn,
  output logic                 cfg_err,
  output logic [OUT_WIDTH-1:0] thermo
);

  localparam logic [WIDTH-1:0] RST_HI = '1;

  wave_mode_e            r_mode;
  logic [STEP_W-1:0]     r_step;
  logic [WIDTH-1:0]      r_lo;
  logic [WIDTH-1:0]      r_hi;
  logic [WIDTH-1:0]      r_count;
  logic                  r_dir_up;
  logic                  r_turn;
  logic                  r_cfg_err;
  logic [OUT_WIDTH-1:0]  r_thermo;

  logic [OUT_WIDTH-1:0]  w_thermo;
  logic [WIDTH:0]        w_s;
  logic [WIDTH:0]        w_cnt_ext;
  logic [WIDTH:0]        w_sum;
  logic [WIDTH:0]        w_lo_s;
  logic [WIDTH-1:0]      w_next_count;
  logic                  w_next_dir;
  logic                  w_next_turn;
  logic                  w_cfg_ok;
  logic [WIDTH-1:0]      w_clamp;
  wave_mode_e            w_cfg_mode;

  thermometer_encoder #(
    .IN_WIDTH  (WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_thermo_enc (
    .i_bin    (r_count),
    .o_thermo (w_thermo)
  );

  always_comb begin
    w_s          = (WIDTH+1)'(r_step);
    w_cnt_ext    = {1'b0, r_count};
    w_sum        = w_cnt_ext + w_s;
    w_lo_s       = {1'b0, r_lo} + w_s;
    w_next_count = r_count;
    w_next_dir   = r_dir_up;
    w_next_turn  = 1'b0;
    // A zero step never moves the count, so it can never hit a bound either.
    if (r_step != '0) begin
      case (r_mode)
        WM_TRI: begin
          if (r_dir_up) begin
            if (w_sum >= {1'b0, r_hi}) begin
              w_next_count = r_hi;
              w_next_dir   = 1'b0;
              w_next_turn  = 1'b1;
            end else begin
              w_next_count = w_sum[WIDTH-1:0];
            end
          end else begin
            if (w_cnt_ext <= w_lo_s) begin
              w_next_count = r_lo;
              w_next_dir   = 1'b1;
              w_next_turn  = 1'b1;
            end else begin
              w_next_count = r_count - WIDTH'(r_step);
            end
          end
        end
        WM_SAW_UP: begin
          if (w_sum > {1'b0, r_hi}) begin
            w_next_count = r_lo;
            w_next_turn  = 1'b1;
          end else begin
            w_next_count = w_sum[WIDTH-1:0];
          end
        end
        WM_SAW_DN: begin
          if (w_cnt_ext < w_lo_s) begin
            w_next_count = r_hi;
            w_next_turn  = 1'b1;
          end else begin
            w_next_count = r_count - WIDTH'(r_step);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_cfg_ok   = (cfg_lo <= cfg_hi);
    w_cfg_mode = wave_mode_e'(cfg_mode);
    if (r_count < cfg_lo)      w_clamp = cfg_lo;
    else if (r_count > cfg_hi) w_clamp = cfg_hi;
    else                       w_clamp = r_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode    <= WM_TRI;
      r_step    <= STEP_W'(RST_STEP);
      r_lo      <= WIDTH'(RST_LO);
      r_hi      <= RST_HI;
      r_count   <= '0;
      r_dir_up  <= 1'b1;
      r_turn    <= 1'b0;
      r_cfg_err <= 1'b0;
      r_thermo  <= '0;
    end else begin
      r_thermo <= w_thermo;
      r_turn   <= 1'b0;
      if (cfg_load) begin
        if (w_cfg_ok) begin
          r_mode  <= w_cfg_mode;
          r_step  <= cfg_step;
          r_lo    <= cfg_lo;
          r_hi    <= cfg_hi;
          r_count <= w_clamp;
          case (w_cfg_mode)
            WM_TRI, WM_SAW_UP: r_dir_up <= 1'b1;
            WM_SAW_DN:         r_dir_up <= 1'b0;
            default:           ;
          endcase
        end else begin
          r_cfg_err <= 1'b1;
        end
      end else if (en) begin
        r_count  <= w_next_count;
        r_dir_up <= w_next_dir;
        r_turn   <= w_next_turn;
      end
    end
  end

  assign count   = r_count;
  assign dir_up  = r_dir_up;
  assign turn    = r_turn;
  assign cfg_err = r_cfg_err;
  assign thermo  = r_thermo;

endmodule

// File: tb/tb_wave_thermo_gen.sv
// Directed self-checking bench for wave_thermo_gen (WIDTH=8, STEP_W=4).
module tb_wave_thermo_gen;

  localparam int WIDTH     = 8;
  localparam int STEP_W    = 4;
  localparam int OUT_WIDTH = 2**WIDTH;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic                 cfg_load;
  logic [1:0]           cfg_mode;
  logic [STEP_W-1:0]    cfg_step;
  logic [WIDTH-1:0]     cfg_lo;
  logic [WIDTH-1:0]     cfg_hi;
  logic [WIDTH-1:0]     count;
  logic                 dir_up;
  logic                 turn;
  logic                 cfg_err;
  logic [OUT_WIDTH-1:0] thermo;

  int n_checks = 0;
  int n_fail   = 0;

  wave_thermo_gen #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_load (cfg_load),
    .cfg_mode (cfg_mode),
    .cfg_step (cfg_step),
    .cfg_lo   (cfg_lo),
    .cfg_hi   (cfg_hi),
    .count    (count),
    .dir_up   (dir_up),
    .turn     (turn),
    .cfg_err  (cfg_err),
    .thermo   (thermo)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst = 1'b0; en = 1'b0; cfg_load = 1'b0;
    cfg_mode = '0; cfg_step = '0; cfg_lo = '0; cfg_hi = '0;
  end

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; cfg_load = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_cfg(input logic [1:0] m, input int st, input int lo, input int hi, input logic with_en);
    cfg_load = 1'b1; en = with_en;
    cfg_mode = m; cfg_step = STEP_W'(st); cfg_lo = WIDTH'(lo); cfg_hi = WIDTH'(hi);
    tick();
    cfg_load = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1;
    tick();
    do_reset();
    n_checks++;
    if (count !== 8'd0 || dir_up !== 1'b1 || turn !== 1'b0 || cfg_err !== 1'b0 || thermo !== '0) begin
      n_fail++;
      $display("FAIL reset got count=%0d dir=%0b turn=%0b err=%0b thermo_ones=%0d exp 0/1/0/0/0",
               count, dir_up, turn, cfg_err, $countones(thermo));
    end
  endtask

  task automatic test_triangle_default();
    int exp_c = 0;
    int prev;
    int turns = 0;
    logic exp_dir = 1'b1;
    logic exp_turn;
    logic [OUT_WIDTH-1:0] exp_th;
    en = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      prev = exp_c;
      exp_turn = 1'b0;
      if (exp_dir) begin
        if (exp_c + 1 >= 255) begin exp_c = 255; exp_dir = 1'b0; exp_turn = 1'b1; end
        else exp_c = exp_c + 1;
      end else begin
        if (exp_c <= 1) begin exp_c = 0; exp_dir = 1'b1; exp_turn = 1'b1; end
        else exp_c = exp_c - 1;
      end
      tick();
      if (turn === 1'b1) turns++;
      exp_th = '0;
      for (int i = 0; i < prev; i++) exp_th[i] = 1'b1;
      n_checks++;
      if (count !== WIDTH'(exp_c) || dir_up !== exp_dir || turn !== exp_turn) begin
        n_fail++;
        $display("FAIL tri_default cyc=%0d got count=%0d dir=%0b turn=%0b exp %0d/%0b/%0b",
                 cyc, count, dir_up, turn, exp_c, exp_dir, exp_turn);
      end
      n_checks++;
      if (thermo !== exp_th) begin
        n_fail++;
        $display("FAIL tri_thermo cyc=%0d got ones=%0d exp ones=%0d", cyc, $countones(thermo), prev);
      end
    end
    en = 1'b0;
    n_checks++;
    if (turns != 2) begin
      n_fail++;
      $display("FAIL tri_turn_count got=%0d exp=2", turns);
    end
  endtask

  task automatic test_saw_up();
    int exp_c [6];
    logic exp_t [6];
    exp_c = '{10, 13, 16, 19, 10, 13};
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    load_cfg(2'd1, 3, 10, 20, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin en = 1'b1; tick(); en = 1'b0; end
      n_checks++;
      if (count !== WIDTH'(exp_c[k]) || turn !== exp_t[k] || dir_up !== 1'b1) begin
        n_fail++;
        $display("FAIL saw_up step=%0d got count=%0d turn=%0b dir=%0b exp %0d/%0b/1",
                 k, count, turn, dir_up, exp_c[k], exp_t[k]);
      end
    end
  endtask

  task automatic test_saw_down();
    int exp_c [5];
    logic exp_t [5];
    exp_c = '{17, 13, 9, 5, 17};
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    en = 1'b1;
    repeat (30) tick();
    en = 1'b0;
    load_cfg(2'd2, 4, 5, 17, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin en = 1'b1; tick(); en = 1'b0; end
      n_checks++;
      if (count !== WIDTH'(exp_c[k]) || turn !== exp_t[k] || dir_up !== 1'b0) begin
        n_fail++;
        $display("FAIL saw_down step=%0d got count=%0d turn=%0b dir=%0b exp %0d/%0b/0",
                 k, count, turn, dir_up, exp_c[k], exp_t[k]);
      end
    end
  endtask

  task automatic test_cfg_err();
    // Starts at count=17 in saw-down step 4 lo 5 hi 17.
    load_cfg(2'd1, 2, 30, 20, 1'b0);
    n_checks++;
    if (cfg_err !== 1'b1 || count !== 8'd17 || dir_up !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err_set got err=%0b count=%0d dir=%0b exp 1/17/0", cfg_err, count, dir_up);
    end
    en = 1'b1; tick(); en = 1'b0;
    n_checks++;
    if (count !== 8'd13) begin
      n_fail++;
      $display("FAIL cfg_err_unchanged got count=%0d exp=13", count);
    end
    load_cfg(2'd0, 1, 0, 255, 1'b0);
    n_checks++;
    if (cfg_err !== 1'b1 || count !== 8'd13 || dir_up !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_err_sticky got err=%0b count=%0d dir=%0b exp 1/13/1", cfg_err, count, dir_up);
    end
    do_reset();
    n_checks++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cfg_err_clear got=%0b exp=0", cfg_err);
    end
  endtask

  task automatic test_load_priority_and_rst();
    en = 1'b1;
    repeat (100) tick();
    n_checks++;
    if (count !== 8'd100) begin
      n_fail++;
      $display("FAIL prio_setup got count=%0d exp=100", count);
    end
    load_cfg(2'd0, 1, 0, 50, 1'b1);
    n_checks++;
    if (count !== 8'd50 || turn !== 1'b0 || dir_up !== 1'b1) begin
      n_fail++;
      $display("FAIL load_prio got count=%0d turn=%0b dir=%0b exp 50/0/1", count, turn, dir_up);
    end
    en = 1'b1; tick();
    n_checks++;
    if (count !== 8'd50 || turn !== 1'b1 || dir_up !== 1'b0) begin
      n_fail++;
      $display("FAIL at_hi_bound got count=%0d turn=%0b dir=%0b exp 50/1/0", count, turn, dir_up);
    end
    tick();
    n_checks++;
    if (count !== 8'd49 || turn !== 1'b0) begin
      n_fail++;
      $display("FAIL after_bound got count=%0d turn=%0b exp 49/0", count, turn);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++;
    if (count !== 8'd0 || thermo !== '0 || dir_up !== 1'b1 || turn !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst got count=%0d ones=%0d dir=%0b turn=%0b exp 0/0/1/0",
               count, $countones(thermo), dir_up, turn);
    end
    en = 1'b0;
  endtask

  task automatic test_hold_and_zero_step();
    int bad;
    load_cfg(2'd0, 0, 0, 255, 1'b0);
    bad = 0;
    en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (count !== 8'd0 || turn !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL zero_step got bad_cycles=%0d exp=0", bad);
    end
    en = 1'b0;
    load_cfg(2'd3, 5, 20, 40, 1'b0);
    bad = 0;
    en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (count !== 8'd20 || turn !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_mode got bad_cycles=%0d exp=0", bad);
    end
    en = 1'b0;
  endtask

  task automatic test_degenerate_range();
    logic exp_dir;
    load_cfg(2'd0, 1, 7, 7, 1'b0);
    exp_dir = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_dir = ~exp_dir;
      tick();
      n_checks++;
      if (count !== 8'd7 || turn !== 1'b1 || dir_up !== exp_dir) begin
        n_fail++;
        $display("FAIL degen_tri k=%0d got count=%0d turn=%0b dir=%0b exp 7/1/%0b",
                 k, count, turn, dir_up, exp_dir);
      end
    end
    en = 1'b0;
    load_cfg(2'd1, 2, 9, 9, 1'b0);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (count !== 8'd9 || turn !== 1'b1) begin
        n_fail++;
        $display("FAIL degen_saw k=%0d got count=%0d turn=%0b exp 9/1", k, count, turn);
      end
    end
    en = 1'b0;
    tick();
    n_checks++;
    if (turn !== 1'b0 || count !== 8'd9) begin
      n_fail++;
      $display("FAIL en_low_hold got count=%0d turn=%0b exp 9/0", count, turn);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_triangle_default();
    test_saw_up();
    test_saw_down();
    test_cfg_err();
    test_load_priority_and_rst();
    test_hold_and_zero_step();
    test_degenerate_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_thermo_gen.md
Name: wave_thermo_gen

Overview:
Parametrised successor to the single-mode up/down counter feeding the thermometer encoder on the pad outputs. Generates a programmable waveform count with triangle, sawtooth-up, sawtooth-down and hold modes. Supports configurable step and lower/upper bounds, and registers a thermometer-coded copy for the output pins. Sits between the top-level IO wrapper and the pads; the wrapper slices `thermo` onto uo_out/uio_out/uio_oe.

Parameters:
WIDTH, 8, count width in bits; bounds and thermometer size derive from it
STEP_W, 4, width of the step-size input
OUT_WIDTH, 2**WIDTH, thermometer width (derived; do not override)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  advance enable; one step per cycle while high
cfg_load  input  1  latch mode/step/lo/hi this cycle
cfg_mode  input  2  0=triangle, 1=saw-up, 2=saw-down, 3=hold
cfg_step  input  STEP_W  step size
cfg_lo  input  WIDTH  lower bound (inclusive)
cfg_hi  input  WIDTH  upper bound (inclusive)
count  output  WIDTH  current registered count
dir_up  output  1  current direction (1=up)
turn  output  1  one-cycle pulse on a bound hit or wrap
cfg_err  output  1  sticky flag; set by an illegal config load
thermo  output  OUT_WIDTH  registered thermometer code of count

Behaviour:
- Reset (rst=1 at posedge):
  - count=0, dir_up=1, turn=0, cfg_err=0, thermo=0.
  - Active config: mode=0, step=1, lo=0, hi=2**WIDTH-1.
  - Reset wins over every other input.
- Config load (cfg_load=1):
  - If cfg_lo<=cfg_hi: commit all four fields to the active registers. Clamp count into [lo,hi]. Set dir_up=1 for modes 0/1, dir_up=0 for mode 2, unchanged for mode 3.
  - If cfg_lo>cfg_hi: the whole load is ignored and cfg_err is set. cfg_err clears only on rst.
  - cfg_load has priority over en: no step is taken that cycle, and turn=0.
- Step (en=1, cfg_load=0). All sums are computed in WIDTH+1 bits; no modular wrap is allowed. Let s=step zero-extended.
  - Triangle, going up: if count+s >= hi, then count<=hi, dir_up<=0, turn<=1. Else count<=count+s.
  - Triangle, going down: if count <= lo+s, then count<=lo, dir_up<=1, turn<=1. Else count<=count-s.
  - Saw-up: if count+s > hi, then count<=lo, turn<=1. Else count+s. dir_up held at 1.
  - Saw-down: if count < lo+s, then count<=hi, turn<=1. Else count-s. dir_up held at 0.
  - Hold: count unchanged, turn=0.
  - step=0 in any mode: count unchanged, turn=0.
- en=0: count, dir_up and config hold; turn=0.
- turn is high for exactly the cycle after the bound event and never stays high two cycles from one event.
- Degenerate range lo==hi:
  - Triangle: count stays at lo, and turn pulses every enabled cycle while dir_up toggles.
  - Saw modes: count stays, and turn pulses every enabled cycle when s>0.
- thermo:
  - thermo[i] = (i < count_q), registered from count, i.e. one cycle of latency behind count.
  - count=0 gives all zeros; count=2**WIDTH-1 gives all bits except the MSB.
- Mid-operation rst returns to reset values in one cycle; thermo reaches 0 on the same edge.

Decomposition:
- Package wave_pkg:
  - enum `wave_mode_e` {WM_TRI, WM_SAW_UP, WM_SAW_DN, WM_HOLD}.
  - Reset constants `RST_STEP`=1 and `RST_LO`=0.
  - RST_HI is computed in the module from WIDTH.
- One sub-module: reuse the existing `thermometer_encoder` (IN_WIDTH=WIDTH, OUT_WIDTH=OUT_WIDTH) combinationally, with its output registered in wave_thermo_gen.
- The step/bound arithmetic stays inline.

Test Plan:
- Reset, en=1, default config, 600 cycles:
  - count climbs 0 to 255, then falls back to 0.
  - turn pulses at count=255 and count=0.
  - thermo popcount equals count delayed by 1 cycle.
- Load mode=1, step=3, lo=10, hi=20, count starts at 10:
  - Sequence 10,13,16,19, then 10 with turn=1.
- Load mode=2, step=4, lo=5, hi=17, count clamped to 17:
  - Sequence 17,13,9,5, then 17 with turn=1.
- Load lo=30, hi=20:
  - Config unchanged, cfg_err=1 until rst.
  - A later valid load does not clear cfg_err.
- cfg_load and en high together at count=100, triangle step=1:
  - No step taken; count clamps per the new bounds.
  - Then rst asserted mid-run: next cycle count=0, thermo=0, dir_up=1.
- Step=0 or mode=3 with en=1 for 50 cycles:
  - count constant, turn never asserted.
